// File: rtl/mac_array_3x3_if.sv
// Job handshake plus operand/result buses between the matmul front end and the 3x3 MAC array.
// Latency: none, wires only.
// Backpressure: none; a start pulsed while busy is dropped by the array, so the front end should wait for done.
//
// master (front end): start, bias_flat, a_in, b_in, threshold
// slave  (array)    : cycle_idx, busy, done, c_valid, c_flat, c_mask
interface mac_array_3x3_if #(
    parameter int DW = 16,
    parameter int AW = 32
);
    logic            start;
    logic [9*DW-1:0] bias_flat;
    logic [3*DW-1:0] a_in;
    logic [3*DW-1:0] b_in;
    logic [AW-1:0]   threshold;
    logic [2:0]      cycle_idx;
    logic            busy;
    logic            done;
    logic            c_valid;
    logic [9*AW-1:0] c_flat;
    logic [8:0]      c_mask;

    modport master (
        output start, bias_flat, a_in, b_in, threshold,
        input  cycle_idx, busy, done, c_valid, c_flat, c_mask
    );

    modport slave (
        input  start, bias_flat, a_in, b_in, threshold,
        output cycle_idx, busy, done, c_valid, c_flat, c_mask
    );
endinterface

// File: rtl/mac_array_3x3.sv
// Output-stationary 3x3 systolic MAC array: C = A*B + bias, plus a per-element signed threshold mask.
// Latency: start accepted at edge t -> accumulate edges t+1..t+7, done/c_valid high after edge t+7.
// Backpressure: none; start is honoured only in IDLE or DONE and silently ignored while busy.
//
// Ports: clk, resetn (async, active-low); bus (slave modport of mac_array_3x3_if):
//   in : start, bias_flat[(3i+j)*DW +: DW], a_in[r*DW +: DW], b_in[c*DW +: DW], threshold
//   out: cycle_idx (skew index for the front end), busy, done (1-cycle pulse), c_valid (level),
//        c_flat[(3i+j)*AW +: AW], c_mask[3i+j]
module mac_array_3x3 #(
    parameter int DW         = 16,
    parameter int AW         = 32,
    parameter int RUN_CYCLES = 7
) (
    input  logic           clk,
    input  logic           resetn,
    mac_array_3x3_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(RUN_CYCLES - 1);

    state_t state_q, state_d;
    logic   load, step, finish;

    logic signed [AW-1:0] acc_q   [3][3];
    logic signed [AW-1:0] acc_nxt [3][3];
    logic signed [DW-1:0] a_src   [3][3];
    logic signed [DW-1:0] b_src   [3][3];
    // The last column never forwards A and the last row never forwards B, so those stages do not exist.
    logic signed [DW-1:0] a_pipe  [3][2];
    logic signed [DW-1:0] b_pipe  [2][3];
    logic signed [AW-1:0] thr_q;
    logic [2:0]           cycle_q;
    logic                 done_q;
    logic                 valid_q;
    logic [8:0]           mask_q;
    logic [8:0]           mask_nxt;

    // Processing elements: A flows right, B flows down, each PE accumulates in place.
    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            logic signed [2*DW-1:0] prod;

            if (j == 0) begin : g_a_edge
                assign a_src[i][j] = bus.a_in[i*DW +: DW];
            end else begin : g_a_link
                assign a_src[i][j] = a_pipe[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_src[i][j] = bus.b_in[j*DW +: DW];
            end else begin : g_b_link
                assign b_src[i][j] = b_pipe[i-1][j];
            end

            assign prod          = a_src[i][j] * b_src[i][j];
            assign acc_nxt[i][j] = acc_q[i][j] + AW'(prod);
            // The mask is taken from the post-final-edge value so it lands together with c_valid.
            assign mask_nxt[3*i+j] = (acc_nxt[i][j] >= thr_q);
            assign bus.c_flat[(3*i+j)*AW +: AW] = acc_q[i][j];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cycle_q == LAST_IDX) begin
                    finish  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    acc_q[i][j] <= '0;
                end
                for (int j = 0; j < 2; j++) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[j][i] <= '0;
                end
            end
            thr_q   <= '0;
            cycle_q <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            done_q <= finish;
            if (load) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        acc_q[i][j] <= AW'($signed(bus.bias_flat[(3*i+j)*DW +: DW]));
                    end
                    for (int j = 0; j < 2; j++) begin
                        a_pipe[i][j] <= '0;
                        b_pipe[j][i] <= '0;
                    end
                end
                thr_q   <= $signed(bus.threshold);
                cycle_q <= '0;
                valid_q <= 1'b0;
            end else if (step) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        acc_q[i][j] <= acc_nxt[i][j];
                    end
                    for (int j = 0; j < 2; j++) begin
                        a_pipe[i][j] <= a_src[i][j];
                        b_pipe[j][i] <= b_src[j][i];
                    end
                end
                // Runs on to 7 on the final edge and parks there while DONE.
                cycle_q <= cycle_q + 3'd1;
                if (finish) begin
                    valid_q <= 1'b1;
                    mask_q  <= mask_nxt;
                end
            end
        end
    end

    assign bus.cycle_idx = cycle_q;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = done_q;
    assign bus.c_valid   = valid_q;
    assign bus.c_mask    = mask_q;
endmodule

// File: doc/mac_array_3x3.md
Name: mac_array_3x3

Overview:
- Output-stationary 3x3 systolic multiply-accumulate array.
- Sits directly downstream of the fused matrix-multiply PCPI front end. It consumes the skewed row feeds of A and column feeds of B, plus the bias matrix, and produces the 9 accumulated results and a threshold bitmask.
- Computes C = A*B + bias in 7 run cycles.
- Exports its run-cycle index so the front end can generate the skew.

Parameters:
- DW, 16, signed operand and bias width.
- AW, 32, signed accumulator/result width; must be >= 2*DW.
- RUN_CYCLES, 7, accumulate cycles per job (2*N+1 for N=3).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse; honoured only in IDLE or DONE.
- bias_flat  in  9*DW  bias(i,j) at bits [(3i+j)*DW +: DW]; sampled on the accepted start edge.
- a_in  in  3*DW  row feed r at bits [r*DW +: DW]; front end drives A[r][k-r] when 0<=k-r<3, else 0, with k=cycle_idx.
- b_in  in  3*DW  column feed c at bits [c*DW +: DW]; front end drives B[k-c][c] when 0<=k-c<3, else 0.
- threshold  in  AW  signed compare level; sampled on the accepted start edge.
- cycle_idx  out  3  run-cycle counter k (0..6 in RUN; holds 7 in DONE).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on the first DONE cycle.
- c_valid  out  1  level; results are valid and held.
- c_flat  out  9*AW  acc(i,j) at bits [(3i+j)*AW +: AW].
- c_mask  out  9  bit 3i+j = (acc(i,j) >= threshold), signed compare.

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: all outputs 0, including cycle_idx, c_flat, c_mask, c_valid and done. Pipeline registers and threshold register are 0.
- IDLE, start=1:
  - Each acc(i,j) loads sign-extended bias(i,j).
  - Clear all a_pipe/b_pipe registers.
  - Latch threshold.
  - Set cycle_idx=0, c_valid=0, and move to RUN.
- RUN, each edge:
  - PE(i,j) uses a_src = (j==0 ? a_in[i] : a_pipe[i][j-1]) and b_src = (i==0 ? b_in[j] : b_pipe[i-1][j]).
  - acc(i,j) += a_src*b_src, computed as a signed DW*DW product sign-extended to AW.
  - a_pipe[i][j] <= a_src and b_pipe[i][j] <= b_src.
  - cycle_idx increments.
- After the edge with cycle_idx==6 (the 7th accumulate): go to DONE, cycle_idx=7, done=1 for that one cycle, c_valid=1.
- c_mask is registered on entry to DONE from the final acc values.
- Latency: start accepted at edge t gives accumulate edges t+1..t+7. done and c_valid are high in the cycle after edge t+7.
- DONE: hold c_flat, c_mask and c_valid indefinitely; done low after its first cycle.
- start in DONE: same action as start in IDLE (back-to-back jobs). c_valid drops on the start edge.
- start while busy: ignored. No effect on accumulators, counter, threshold or bias sampling.
- Arithmetic: accumulators wrap modulo 2^AW (two's complement). No saturation, no overflow flag.
- Async reset asserted mid-RUN or in DONE: immediate return to IDLE with every register cleared. Partial results are discarded.
- a_in and b_in are ignored outside RUN.
- bias_flat and threshold are ignored except on an accepted start.

Test Plan:
- A=identity, B=[[1,2,3],[4,5,6],[7,8,9]], bias=0, threshold=0, start pulse:
  - busy high for exactly 7 cycles, then a 1-cycle done.
  - c_flat = B; c_mask = 9'h1FF.
- A=all 1, B=all 1, bias=all 1, threshold=5 -> every acc=4, c_mask=0. Repeat with threshold=4 -> c_mask=9'h1FF.
- A=[[-2,0,0],[0,-2,0],[0,0,-2]], B=all 40, bias=all -5, threshold=-70:
  - every acc = -85, sign-correct in 32 bits.
  - c_mask=0.
- Operand extremes: A(0,0)=B(0,0)=-32768, all other entries 0, bias(0,0)=0 -> acc(0,0)=32'h40000000, all others 0.
- Pulse start at cycle_idx=3 mid-RUN -> ignored: done still at the original time, results unchanged. Then pulse start in the done cycle -> new job begins, c_valid low next cycle, new done 8 cycles after.
- Deassert resetn at cycle_idx=4:
  - outputs immediately 0, state IDLE.
  - After release, a fresh job with the identity stimulus gives c_flat = B.
